// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame timing,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DBIT_DEF    = 8;
  localparam int OVS_DEF     = 16;
  localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, stop period, all timed in TICKs.
// Define UART_TX_PARITY_EN to append an even-parity bit after the last data bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int OVS     = OVS_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            TICK,
  input  logic            TX_START,
  input  logic [DBIT-1:0] DIN,
  output logic            TX_DONE,
  output logic            TX,
  output logic            TX_BUSY,
  output logic [1:0]      STATE
);

  // Tick counter must reach both OVS-1 and SB_TICK-1.
  localparam int S_MAX = (SB_TICK > OVS) ? SB_TICK : OVS;
  localparam int S_W   = (S_MAX <= 16) ? 4 : $clog2(S_MAX);
`ifdef UART_TX_PARITY_EN
  localparam int N_W    = 4;
  localparam int LAST_N = DBIT;
`else
  localparam int N_W    = 3;
  localparam int LAST_N = DBIT - 1;
`endif

  // Handshake: TX_START is sampled only while IDLE; a request in any other
  // state is dropped, and TX_BUSY reports (from the state register) when that is.
  uart_state_e     state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (TX_START) begin
          b_d     = DIN;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^DIN;
`endif
        end
      end
      ST_START: begin
        if (TICK) begin
          if (s_q == S_W'(OVS - 1)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (TICK) begin
          if (s_q == S_W'(OVS - 1)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_W'(LAST_N)) state_d = ST_STOP;
            else                     n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (TICK) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is computed from the next state so TX changes together with STATE.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START: tx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      ST_DATA:  tx_d = (n_d == N_W'(DBIT)) ? par_d : b_d[0];
`else
      ST_DATA:  tx_d = b_d[0];
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign TX      = tx_q;
  assign TX_DONE = done_q;
  assign TX_BUSY = (state_q != ST_IDLE);
  assign STATE   = state_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serializes one byte per request as start bit, DBIT data bits (LSB first) and stop bit(s).
- Counterpart of the UART receiver; shares its 16x-oversampling baud TICK from the existing baud-rate generator.
- Sits between the host-side control logic (byte source) and the TX pin.
- Idle line is high; all timing counts TICK pulses, never raw CLK cycles.

Parameters:
- DBIT, 8, number of data bits per frame (valid range 5..8).
- SB_TICK, 16, TICK pulses per stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVS, 16, TICK pulses per start/data/parity bit (oversampling factor, matches receiver).

Ports:
- CLK, input, 1, system clock; all state changes on rising edge.
- RESET, input, 1, asynchronous active-high reset.
- TICK, input, 1, one-CLK-wide pulse at OVS x baud rate.
- TX_START, input, 1, request to send DIN; honoured only in IDLE.
- DIN, input, DBIT, byte to transmit; captured on acceptance.
- TX_DONE, output, 1, one-CLK pulse at end of stop period.
- TX, output, 1, serial line (registered).
- TX_BUSY, output, 1, high from acceptance until return to IDLE.
- STATE, output, 2, current FSM state for debug: 0 IDLE, 1 START, 2 DATA, 3 STOP.

Behaviour:
- Reset values (async, immediate, including mid-frame):
  - STATE = IDLE, TX = 1, TX_DONE = 0, TX_BUSY = 0.
  - Tick counter, bit counter and shift register all cleared.
  - A partially sent frame is abandoned; the line returns high at once.
- Internal registers:
  - 4-bit tick counter s (must hold OVS-1 and SB_TICK-1; widen if SB_TICK > 16).
  - 3-bit bit counter n (4 bits if parity is enabled).
  - DBIT-bit shift register b; registered tx_reg drives TX.
- IDLE:
  - TX = 1.
  - TX_START = 1 → latch b <= DIN, s <= 0, go to START, TX_BUSY = 1 next cycle.
  - TICK is irrelevant in IDLE.
  - A TICK in the acceptance cycle is not counted.
- START:
  - TX = 0.
  - On each TICK: if s == OVS-1 then s <= 0, n <= 0, go to DATA; else s <= s+1.
- DATA:
  - TX = b[0].
  - On TICK with s == OVS-1: s <= 0, b <= b >> 1.
  - Then if n == DBIT-1 go to STOP (or send parity, see Optional Feature); else n <= n+1.
- STOP:
  - TX = 1.
  - On TICK with s == SB_TICK-1: go to IDLE, TX_DONE = 1 for exactly one CLK, TX_BUSY = 0.
- Frame length = (1 + DBIT) x OVS + SB_TICK TICK pulses; 160 for the defaults.
- TX_START while TX_BUSY is ignored; DIN changes after acceptance do not affect the frame.
- Back-to-back:
  - TX_START asserted in the same cycle TX_DONE is high (STATE already IDLE) is accepted.
  - The next start bit begins in the following cycle; no idle gap is required.
- TICK held high continuously is legal; each CLK then counts as one tick.
- No combinational path from any input to TX.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Even parity of the latched byte (XOR of DIN at acceptance) is sent as one extra bit after the last data bit.
  - The parity bit lasts OVS ticks and is sent within the DATA state (n counts to DBIT).
  - Frame becomes (2 + DBIT) x OVS + SB_TICK ticks; STATE encoding is unchanged.
- When undefined: no parity bit, and no parity logic is synthesized.

Decomposition:
- Shared package uart_pkg holds:
  - State encodings ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3 (shared with the receiver).
  - Default OVS = 16 and SB_TICK constants.
- No sub-module: a single FSM plus datapath. The baud tick generator stays external and is shared with the receiver.

Test Plan:
- Reset during DATA of a frame (DIN=8'h3C) → TX = 1, STATE = 0, TX_BUSY = 0 immediately. A new TX_START with DIN=8'h81 then sends a complete, correct frame.
- TICK every 4 CLK, DIN=8'hA5, TX_START for 1 cycle:
  - TX low for 16 ticks, then bits 1,0,1,0,0,1,0,1 at 16 ticks each, then high for 16 ticks.
  - TX_DONE is a single pulse 640 CLK after acceptance (±4).
- TX_START pulsed mid-frame with DIN=8'hFF → ignored; the first frame's bits are unchanged and only one TX_DONE is produced.
- TX_START held high continuously with DIN=8'h55 → consecutive frames with no idle gap; TX_DONE pulses every 160 ticks; STATE cycles 1→2→3→0→1.
- SB_TICK=32 build, DIN=8'h00 → stop period lasts 32 ticks and total frame is 176 ticks.
- With UART_TX_PARITY_EN defined:
  - DIN=8'h07 → parity bit 1 after bit 7; frame is 176 ticks.
  - DIN=8'h03 → parity bit 0.
